// File: rtl/sumador_pkg.sv
// Shared definitions for the pipelined adder: operation encoding, segment sizing
// and the WIDTH/STAGES configuration check.
package sumador_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  function automatic int unsigned seg_width(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

  // WIDTH must split into STAGES equal, non-empty segments
  function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/sumador_segmento.sv
// One registered carry-chain segment: SEG-bit add with carry-in, producing the
// sum, the carry out and the carry into the segment MSB.
module sumador_segmento #(
  parameter int unsigned SEG = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  logic [SEG:0] total;
  logic         msb_cin;

  always_comb begin
    total   = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
    // carry into the MSB recovered from the MSB sum bit
    msb_cin = a[SEG-1] ^ b[SEG-1] ^ total[SEG-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
      cmsb <= 1'b0;
    end else if (en) begin
      sum  <= total[SEG-1:0];
      cout <= total[SEG];
      cmsb <= msb_cin;
    end
  end

endmodule

// File: rtl/sumador_segmentado.sv
// Pipelined add/subtract unit with valid/ready flow control and carry/overflow/zero flags.
// Optional signed saturation of the result when SUMADOR_SAT_EN is defined.
module sumador_segmentado
  import sumador_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sal,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned SEG  = seg_width(WIDTH, STAGES);
  localparam int unsigned LAST = STAGES - 1;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("sumador_segmentado: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  logic adv;
  op_t  op;

  // whole pipe advances together; stalls only when the output slot is full and not taken
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign op       = sub ? OP_SUB : OP_ADD;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * SEG;
    localparam int unsigned RW = WIDTH - LO;

    logic [RW-1:0]       a_d, b_d;
    logic                cin_d, v_d, v_q;
    logic [SEG-1:0]      sum_q;
    logic                cout_q, cmsb_q;
    logic [LO+SEG-1:0]   r_q;

    if (k == 0) begin : g_in
      assign a_d   = a;
      assign b_d   = (op == OP_SUB) ? ~b : b;
      assign cin_d = (op == OP_SUB);
      assign v_d   = in_valid;
    end else begin : g_in
      assign a_d   = g_stage[k-1].g_skew.ah_q;
      assign b_d   = g_stage[k-1].g_skew.bh_q;
      assign cin_d = g_stage[k-1].cout_q;
      assign v_d   = g_stage[k-1].v_q;
    end

    always_ff @(posedge clk) begin
      if (rst)      v_q <= 1'b0;
      else if (adv) v_q <= v_d;
    end

    sumador_segmento #(.SEG(SEG)) u_seg (
      .clk  (clk),
      .rst  (rst),
      .en   (adv),
      .a    (a_d[SEG-1:0]),
      .b    (b_d[SEG-1:0]),
      .cin  (cin_d),
      .sum  (sum_q),
      .cout (cout_q),
      .cmsb (cmsb_q)
    );

    // operand segments not yet consumed ride along to the next stage
    if (k < LAST) begin : g_skew
      logic [RW-SEG-1:0] ah_q, bh_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          ah_q <= '0;
          bh_q <= '0;
        end else if (adv) begin
          ah_q <= a_d[RW-1:SEG];
          bh_q <= b_d[RW-1:SEG];
        end
      end
    end

    if (k == 0) begin : g_res
      assign r_q = sum_q;
    end else begin : g_res
      logic [LO-1:0] lo_q;
      always_ff @(posedge clk) begin
        if (rst)      lo_q <= '0;
        else if (adv) lo_q <= g_stage[k-1].r_q;
      end
      assign r_q = {sum_q, lo_q};
    end
  end

  logic [WIDTH-1:0] raw;
  logic             raw_cout, raw_ovf, fin_valid;

  assign raw       = g_stage[LAST].r_q;
  assign raw_cout  = g_stage[LAST].cout_q;
  assign raw_ovf   = g_stage[LAST].cout_q ^ g_stage[LAST].cmsb_q;
  assign fin_valid = g_stage[LAST].v_q;

`ifdef SUMADOR_SAT_EN
  // on overflow the wrapped MSB is the inverse of the true sign
  always_comb begin
    sal = raw;
    if (raw_ovf) sal = raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
  end
`else
  assign sal = raw;
`endif

  assign out_valid = fin_valid;
  assign carry_out = fin_valid & raw_cout;
  assign overflow  = fin_valid & raw_ovf;
  assign zero      = fin_valid & (sal == '0);

endmodule
